// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice reused LSB first, one bit per clock; WIDTH+1 edges from start to done.
// Optional subtract mode behind SERIAL_ADDER_SUB_EN (adds Sub port); start is ignored while busy or done.
module serial_adder_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic             cy_q, cy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic             sub_sel;
    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] acc_next;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = Sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign s_bit    = sha_q[0] ^ shb_q[0] ^ cy_q;
    assign c_bit    = (sha_q[0] & shb_q[0]) | (cy_q & (sha_q[0] ^ shb_q[0]));
    // Accumulator keeps WIDTH-1 collected bits; the current bit completes the word.
    assign acc_next = {s_bit, acc_q};

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        acc_d   = acc_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sha_d   = A;
                    shb_d   = sub_sel ? ~B : B;
                    cy_d    = sub_sel ? 1'b1 : Cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sha_d = sha_q >> 1;
                shb_d = shb_q >> 1;
                acc_d = acc_next[WIDTH-1:1];
                cy_d  = c_bit;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = acc_next;
                    carry_d = c_bit;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            acc_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            acc_q   <= acc_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign Sum   = sum_q;
    assign Carry = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: expected {Carry,Sum} queued at start, compared on each done pulse.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Carry;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Carry (Carry)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    int         done_cyc[$];
    logic [W:0] exp_q[$];
    logic [W:0] last_res = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic s);
        logic [W-1:0] bb;
        bb = s ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : cin)};
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("sum", Sum, e[W-1:0]);
                check("carry", Carry, e[W]);
            end
        end
    end

    // Drives one start cycle in IDLE; returns after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic s, output logic [W:0] e);
        @(posedge clk); #1;
        A = a; B = b; Cin = cin; sub = s; start = 1'b1;
        e = model(a, b, cin, s);
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for done, counting busy cycles and checking the old result is held while busy.
    task automatic wait_done(output int bc);
        int n;
        logic held_bad;
        bc = 0;
        n = 0;
        held_bad = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            if (busy) begin
                bc++;
                if ({Carry, Sum} !== last_res) held_bad = 1'b1;
            end
            n++;
        end
        check("done_timeout", (n >= 60), 0);
        check("sum_held", held_bad, 0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic s);
        logic [W:0] e;
        int bc;
        launch(a, b, cin, s, e);
        check("busy_after_accept", busy, 1);
        wait_done(bc);
        check("busy_cycles", bc, W);
        last_res = e;
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [W:0] e;
        int bc;
        int base;
        int n;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", Sum, 0);
        check("rst_carry", Carry, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(8'h5A, 8'hA5, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'hC3, 8'h7E, 1'b1, 1'b0);

        // start re-pulsed mid-run with different operands must be ignored
        base = done_cnt;
        launch(8'h12, 8'h34, 1'b0, 1'b0, e);
        @(posedge clk); @(posedge clk); #1;
        A = 8'h01; B = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(bc);
        last_res = e;
        repeat (W + 4) @(negedge clk);
        check("ignored_start_done_count", done_cnt - base, 1);

        // reset mid-run aborts
        base = done_cnt;
        launch(8'h77, 8'h11, 1'b0, 1'b0, e);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", Sum, 0);
        check("abort_carry", Carry, 0);
        void'(exp_q.pop_back());
        last_res = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("abort_no_done", done_cnt - base, 0);
        run_op(8'h0F, 8'hF1, 1'b0, 1'b0);

        // level-held start chains three operations
        base = done_cnt;
        @(posedge clk); #1;
        A = 8'h33; B = 8'h44; Cin = 1'b1; sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h33, 8'h44, 1'b1, 1'b0));
        n = 0;
        while (done_cnt - base < 3 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("held_timeout", (n >= 100), 0);
        if (done_cyc.size() >= 3) begin
            check("held_gap1", done_cyc[done_cyc.size()-2] - done_cyc[done_cyc.size()-3], W + 2);
            check("held_gap2", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], W + 2);
        end
        last_res = model(8'h33, 8'h44, 1'b1, 1'b0);
        repeat (W + 4) @(negedge clk);
        check("held_stop_count", done_cnt - base, 3);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1);
        run_op(8'h01, 8'h02, 1'b1, 1'b1);
        run_op(8'h5A, 8'hA5, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b1);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
